cdc_sync_bank: RTL and testbench
================================

# cdc_sync_bank

Parametrised HF_CLK-domain synchroniser bank, successor to the fixed-width control/status synchroniser. Brings asynchronous level signals, toggle-encoded event flags and one multi-bit configuration bus into the HF_CLK domain. Provides configurable synchroniser depth, event pulse/sticky generation, a toggle-handshake bus capture FSM with settle delay, and a reset synchroniser output. It sits between the register/SPI-side logic and the HF_CLK sampling, FIFO and ADC control logic.

## Interface
Parameters:
- NSTAGES, 2: flip-flop stages per synchroniser; legal range ≥2.
- NLVL, 8: number of level-signal channels.
- NEVT, 8: number of toggle-encoded event channels.
- BUSW, 32: configuration bus width.
- SETTLE_CYC, 2: HF_CLK cycles waited after a bus toggle is detected, before capture; legal range ≥0.
- BUS_RSTVAL, 0: BUS_OUT reset value (BUSW bits).

Ports:
- HF_CLK  in  1  sole clock.
- RST  in  1  reset, asynchronous, active-high.
- RST_SYNC  out  1  active-high reset; asserts asynchronously with RST, deasserts NSTAGES edges after RST falls.
- LVL_IN  in  NLVL  asynchronous quasi-static levels.
- LVL_SYNC  out  NLVL  synchronised levels.
- EVT_TOG  in  NEVT  per-channel event toggles; the source inverts a bit once per event.
- EVT_PULSE  out  NEVT  one-cycle pulse per event.
- EVT_STICKY  out  NEVT  sticky event flags.
- EVT_CLR  in  NEVT  synchronous per-bit clear for EVT_STICKY.
- BUS_IN  in  BUSW  source bus; held stable from a BUS_TOG toggle until BUS_ACK matches it.
- BUS_TOG  in  1  source request toggle.
- BUS_ACK  out  1  acknowledge toggle; equals the synchronised BUS_TOG after capture.
- BUS_OUT  out  BUSW  captured bus.
- BUS_VALID  out  1  one-cycle pulse on each capture.
- BUS_ERR  out  1  sticky protocol-violation flag; cleared only by RST.

## Operation
- **Reset (RST high).** All outputs are forced as follows:
  - LVL_SYNC=0, EVT_PULSE=0, EVT_STICKY=0.
  - BUS_OUT=BUS_RSTVAL, BUS_VALID=0, BUS_ACK=0, BUS_ERR=0.
  - RST_SYNC=1.
  - All synchroniser flops and toggle history registers = 0; FSM=IDLE.
- **Levels.** Each LVL_IN bit passes through an NSTAGES flop chain. There is no cross-bit coherency guarantee.
- **Events.**
  - Each EVT_TOG bit is synchronised through NSTAGES flops.
  - A history register holds the previous synchronised value; EVT_PULSE = synchronised XOR history, registered.
  - EVT_STICKY bit sets on its pulse and clears on EVT_CLR. If set and clear occur in the same cycle, set wins.
- **Bus FSM.** BUS_TOG is synchronised through NSTAGES flops; a change is detected against the tog_seen register.
  - **IDLE:** on change, latch tog_seen, load the settle counter with SETTLE_CYC, go to SETTLE. If SETTLE_CYC=0, go directly to CAPTURE.
  - **SETTLE:** decrement the counter; at 0 go to CAPTURE. If another change is detected: set BUS_ERR, re-latch tog_seen, reload the counter, stay in SETTLE.
  - **CAPTURE (one cycle):** BUS_OUT←BUS_IN, BUS_VALID=1, BUS_ACK←tog_seen, return to IDLE.
- **Counter width.** The settle counter is $clog2(SETTLE_CYC+1) bits, minimum 1.
- **BUS_IN sampling.** BUS_IN is never sampled outside CAPTURE.

## Timing
- **LVL_SYNC:** follows LVL_IN NSTAGES edges after the first edge that samples the new value.
- **EVT_PULSE:** asserts at edge NSTAGES+1 after the first sampling edge, high for exactly one cycle. EVT_STICKY sets on the same edge.
- **Event rate:** toggles spaced less than NSTAGES+1 cycles apart may merge; this is the source's responsibility.
- **BUS_VALID/BUS_OUT/BUS_ACK:** all update on the same edge, NSTAGES+1+SETTLE_CYC+1 edges after the first edge sampling the new BUS_TOG.
- **RST mid-capture:** aborts immediately. BUS_OUT returns to BUS_RSTVAL and BUS_ACK to 0; the source must re-request.
- **RST_SYNC:** deasserts on edge NSTAGES after RST falls. The internal logic uses RST directly, not RST_SYNC.

## Configuration
- Macro: `CDC_SYNC_BANK_STICKY_EN`.
- **Defined:** sticky registers and EVT_CLR behave as specified above.
- **Undefined:** EVT_STICKY is tied to 0, EVT_CLR is ignored, and no sticky flops are built. All other behaviour is identical.

## Structure
- **Package cdc_sync_pkg:**
  - bus FSM state enum (IDLE, SETTLE, CAPTURE);
  - constant CDC_MIN_STAGES=2;
  - settle counter width function.
- **Sub-module cdc_sync_ff:**
  - parameters WIDTH and NSTAGES; async active-high reset to 0;
  - instantiated for LVL_IN, EVT_TOG and BUS_TOG.
  - The reset synchroniser is a separate small always block, since it has different reset semantics.
- **Elaboration check:** an assertion fails if NSTAGES < CDC_MIN_STAGES.

## Test plan
All scenarios use default parameters (NSTAGES=2, SETTLE_CYC=2, BUSW=32).
1. RST pulse then release. All outputs hold their reset values while RST is high; RST_SYNC falls exactly 2 edges after RST falls.
2. LVL_IN 0x00→0xA5. LVL_SYNC=0xA5 after 2 edges and is unchanged before then.
3. EVT_TOG[3] toggles once. Single-cycle EVT_PULSE=0x08 at edge 3; EVT_STICKY[3]=1 until EVT_CLR[3]. With EVT_CLR and a new event in the same cycle, EVT_STICKY stays 1.
4. BUS_IN=0xDEADBEEF, BUS_TOG 0→1. BUS_OUT=0xDEADBEEF, BUS_VALID pulse and BUS_ACK=1 at edge 6; BUS_ERR=0.
5. BUS_TOG toggled twice, 1 cycle apart after the first is detected. BUS_ERR=1; a single capture occurs with BUS_ACK equal to the final toggle value.
6. RST asserted during SETTLE. BUS_OUT=BUS_RSTVAL and BUS_ACK=0 immediately, no BUS_VALID; the capture after release works normally.

Source files
------------

// File: rtl/cdc_sync_pkg.sv
// Shared types and helpers for the HF_CLK synchroniser bank.
package cdc_sync_pkg;

  localparam int CDC_MIN_STAGES = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2
  } bus_state_t;

  function automatic int settle_cnt_w(input int settle);
    int w;
    w = $clog2(settle + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cdc_sync_ff.sv
// Multi-bit flop-chain synchroniser, async active-high reset to 0.
module cdc_sync_ff
  import cdc_sync_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int NSTAGES = CDC_MIN_STAGES
) (
  input  logic             HF_CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [NSTAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge HF_CLK or posedge RST) begin
    if (RST) chain <= '0;
    else     chain <= {chain[NSTAGES-2:0], d};
  end

  assign q = chain[NSTAGES-1];

endmodule

// File: rtl/cdc_sync_bank.sv
// HF_CLK synchroniser bank: levels, toggle events, toggle-handshake bus, reset.
// Sticky event flags are built only when CDC_SYNC_BANK_STICKY_EN is defined.
module cdc_sync_bank
  import cdc_sync_pkg::*;
#(
  parameter int              NSTAGES    = 2,
  parameter int              NLVL       = 8,
  parameter int              NEVT       = 8,
  parameter int              BUSW       = 32,
  parameter int              SETTLE_CYC = 2,
  parameter logic [BUSW-1:0] BUS_RSTVAL = '0
) (
  input  logic            HF_CLK,
  input  logic            RST,
  output logic            RST_SYNC,
  input  logic [NLVL-1:0] LVL_IN,
  output logic [NLVL-1:0] LVL_SYNC,
  input  logic [NEVT-1:0] EVT_TOG,
  output logic [NEVT-1:0] EVT_PULSE,
  output logic [NEVT-1:0] EVT_STICKY,
  input  logic [NEVT-1:0] EVT_CLR,
  input  logic [BUSW-1:0] BUS_IN,
  input  logic            BUS_TOG,
  output logic            BUS_ACK,
  output logic [BUSW-1:0] BUS_OUT,
  output logic            BUS_VALID,
  output logic            BUS_ERR
);

  localparam int CW = settle_cnt_w(SETTLE_CYC);

  if (NSTAGES < CDC_MIN_STAGES) begin : g_chk
    $error("cdc_sync_bank: NSTAGES below minimum");
  end

  logic [NSTAGES-1:0] rst_q;

  always_ff @(posedge HF_CLK or posedge RST) begin
    if (RST) rst_q <= '1;
    else     rst_q <= {rst_q[NSTAGES-2:0], 1'b0};
  end

  assign RST_SYNC = rst_q[NSTAGES-1];

  cdc_sync_ff #(.WIDTH(NLVL), .NSTAGES(NSTAGES)) u_lvl (
    .HF_CLK (HF_CLK),
    .RST    (RST),
    .d      (LVL_IN),
    .q      (LVL_SYNC)
  );

  logic [NEVT-1:0] evt_s;
  logic [NEVT-1:0] evt_hist;
  logic [NEVT-1:0] evt_edge;

  cdc_sync_ff #(.WIDTH(NEVT), .NSTAGES(NSTAGES)) u_evt (
    .HF_CLK (HF_CLK),
    .RST    (RST),
    .d      (EVT_TOG),
    .q      (evt_s)
  );

  assign evt_edge = evt_s ^ evt_hist;

  always_ff @(posedge HF_CLK or posedge RST) begin
    if (RST) begin
      evt_hist  <= '0;
      EVT_PULSE <= '0;
    end else begin
      evt_hist  <= evt_s;
      EVT_PULSE <= evt_edge;
    end
  end

`ifdef CDC_SYNC_BANK_STICKY_EN
  // Set wins over a same-cycle clear.
  always_ff @(posedge HF_CLK or posedge RST) begin
    if (RST) EVT_STICKY <= '0;
    else     EVT_STICKY <= (EVT_STICKY & ~EVT_CLR) | evt_edge;
  end
`else
  logic unused_evt_clr;
  assign unused_evt_clr = ^EVT_CLR;
  assign EVT_STICKY     = '0;
`endif

  logic          tog_s;
  logic          tog_seen;
  logic [CW-1:0] cnt;
  bus_state_t    state;

  cdc_sync_ff #(.WIDTH(1), .NSTAGES(NSTAGES)) u_tog (
    .HF_CLK (HF_CLK),
    .RST    (RST),
    .d      (BUS_TOG),
    .q      (tog_s)
  );

  always_ff @(posedge HF_CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      tog_seen  <= 1'b0;
      cnt       <= '0;
      BUS_OUT   <= BUS_RSTVAL;
      BUS_VALID <= 1'b0;
      BUS_ACK   <= 1'b0;
      BUS_ERR   <= 1'b0;
    end else begin
      BUS_VALID <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (tog_s != tog_seen) begin
            tog_seen <= tog_s;
            cnt      <= CW'(SETTLE_CYC);
            state    <= (SETTLE_CYC == 0) ? S_CAPTURE : S_SETTLE;
          end
        end
        S_SETTLE: begin
          // A second request while settling restarts the wait.
          if (tog_s != tog_seen) begin
            BUS_ERR  <= 1'b1;
            tog_seen <= tog_s;
            cnt      <= CW'(SETTLE_CYC);
          end else if (cnt <= CW'(1)) begin
            cnt   <= '0;
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_CAPTURE: begin
          BUS_OUT   <= BUS_IN;
          BUS_VALID <= 1'b1;
          BUS_ACK   <= tog_seen;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_sync_bank.sv
// Directed self-checking bench for cdc_sync_bank at default parameters.
module tb_cdc_sync_bank;

  logic        HF_CLK = 1'b0;
  logic        RST;
  logic        RST_SYNC;
  logic [7:0]  LVL_IN;
  logic [7:0]  LVL_SYNC;
  logic [7:0]  EVT_TOG;
  logic [7:0]  EVT_PULSE;
  logic [7:0]  EVT_STICKY;
  logic [7:0]  EVT_CLR;
  logic [31:0] BUS_IN;
  logic        BUS_TOG;
  logic        BUS_ACK;
  logic [31:0] BUS_OUT;
  logic        BUS_VALID;
  logic        BUS_ERR;

  int tests  = 0;
  int failed = 0;
  int ncap;
  logic        cap_ack;
  logic [31:0] cap_out;

`ifdef CDC_SYNC_BANK_STICKY_EN
  localparam logic [7:0] STK3 = 8'h08;
`else
  localparam logic [7:0] STK3 = 8'h00;
`endif

  cdc_sync_bank dut (
    .HF_CLK     (HF_CLK),
    .RST        (RST),
    .RST_SYNC   (RST_SYNC),
    .LVL_IN     (LVL_IN),
    .LVL_SYNC   (LVL_SYNC),
    .EVT_TOG    (EVT_TOG),
    .EVT_PULSE  (EVT_PULSE),
    .EVT_STICKY (EVT_STICKY),
    .EVT_CLR    (EVT_CLR),
    .BUS_IN     (BUS_IN),
    .BUS_TOG    (BUS_TOG),
    .BUS_ACK    (BUS_ACK),
    .BUS_OUT    (BUS_OUT),
    .BUS_VALID  (BUS_VALID),
    .BUS_ERR    (BUS_ERR)
  );

  always #5 HF_CLK = ~HF_CLK;

  task automatic step(input int n = 1);
    repeat (n) @(posedge HF_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst_outs(input string tag);
    chk({tag, "_lvl"}, 64'(LVL_SYNC), 64'h0);
    chk({tag, "_pulse"}, 64'(EVT_PULSE), 64'h0);
    chk({tag, "_sticky"}, 64'(EVT_STICKY), 64'h0);
    chk({tag, "_out"}, 64'(BUS_OUT), 64'h0);
    chk({tag, "_valid"}, 64'(BUS_VALID), 64'h0);
    chk({tag, "_ack"}, 64'(BUS_ACK), 64'h0);
    chk({tag, "_err"}, 64'(BUS_ERR), 64'h0);
    chk({tag, "_rsync"}, 64'(RST_SYNC), 64'h1);
  endtask

  initial begin
    RST = 1'b1; LVL_IN = 8'hFF; EVT_TOG = 8'hFF; EVT_CLR = 8'h00;
    BUS_IN = 32'h5555_AAAA; BUS_TOG = 1'b1;
    step(3);
    chk_rst_outs("rst_hold");
    LVL_IN = 8'h00; EVT_TOG = 8'h00; BUS_TOG = 1'b0;
    step(2);
    chk_rst_outs("rst_hold2");
    RST = 1'b0;
    #1 chk("rsync_rel0", 64'(RST_SYNC), 64'h1);
    step();
    chk("rsync_rel1", 64'(RST_SYNC), 64'h1);
    step();
    chk("rsync_rel2", 64'(RST_SYNC), 64'h0);

    LVL_IN = 8'hA5;
    step();
    chk("lvl_e1", 64'(LVL_SYNC), 64'h00);
    step();
    chk("lvl_e2", 64'(LVL_SYNC), 64'hA5);
    LVL_IN = 8'h3C;
    step();
    chk("lvl2_e1", 64'(LVL_SYNC), 64'hA5);
    step();
    chk("lvl2_e2", 64'(LVL_SYNC), 64'h3C);

    EVT_TOG = 8'h08;
    step(2);
    chk("evt_e2", 64'(EVT_PULSE), 64'h00);
    step();
    chk("evt_e3", 64'(EVT_PULSE), 64'h08);
    chk("stk_e3", 64'(EVT_STICKY), 64'(STK3));
    step();
    chk("evt_e4", 64'(EVT_PULSE), 64'h00);
    chk("stk_e4", 64'(EVT_STICKY), 64'(STK3));
    step(2);
    chk("stk_hold", 64'(EVT_STICKY), 64'(STK3));
    EVT_CLR = 8'h08;
    step();
    chk("stk_clr", 64'(EVT_STICKY), 64'h00);
    EVT_CLR = 8'h00;
    EVT_TOG = 8'h00;
    step(2);
    EVT_CLR = 8'h08;
    step();
    chk("evt2_e3", 64'(EVT_PULSE), 64'h08);
    chk("stk_setwins", 64'(EVT_STICKY), 64'(STK3));
    EVT_CLR = 8'h00;
    step();
    chk("stk_after", 64'(EVT_STICKY), 64'(STK3));

    BUS_IN = 32'hDEAD_BEEF; BUS_TOG = 1'b1;
    step(5);
    chk("bus_e5_valid", 64'(BUS_VALID), 64'h0);
    chk("bus_e5_ack", 64'(BUS_ACK), 64'h0);
    chk("bus_e5_out", 64'(BUS_OUT), 64'h0);
    step();
    chk("bus_e6_valid", 64'(BUS_VALID), 64'h1);
    chk("bus_e6_out", 64'(BUS_OUT), 64'hDEAD_BEEF);
    chk("bus_e6_ack", 64'(BUS_ACK), 64'h1);
    chk("bus_e6_err", 64'(BUS_ERR), 64'h0);
    step();
    chk("bus_e7_valid", 64'(BUS_VALID), 64'h0);

    BUS_IN = 32'h1234_5678; BUS_TOG = 1'b0;
    step(2);
    BUS_TOG = 1'b1;
    ncap = 0; cap_ack = 1'b0; cap_out = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (BUS_VALID) begin
        ncap++;
        cap_ack = BUS_ACK;
        cap_out = BUS_OUT;
      end
    end
    chk("dbl_ncap", 64'(ncap), 64'd1);
    chk("dbl_ack", 64'(cap_ack), 64'h1);
    chk("dbl_out", 64'(cap_out), 64'h1234_5678);
    chk("dbl_err", 64'(BUS_ERR), 64'h1);

    BUS_IN = 32'hCAFE_F00D; BUS_TOG = 1'b0;
    step(4);
    RST = 1'b1;
    #1;
    chk("mid_out", 64'(BUS_OUT), 64'h0);
    chk("mid_ack", 64'(BUS_ACK), 64'h0);
    chk("mid_valid", 64'(BUS_VALID), 64'h0);
    chk("mid_err", 64'(BUS_ERR), 64'h0);
    chk("mid_rsync", 64'(RST_SYNC), 64'h1);
    step(2);
    RST = 1'b0;
    ncap = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (BUS_VALID) ncap++;
    end
    chk("mid_nocap", 64'(ncap), 64'd0);
    BUS_IN = 32'h0BAD_F00D; BUS_TOG = 1'b1;
    step(5);
    chk("re_e5_valid", 64'(BUS_VALID), 64'h0);
    step();
    chk("re_e6_valid", 64'(BUS_VALID), 64'h1);
    chk("re_e6_out", 64'(BUS_OUT), 64'h0BAD_F00D);
    chk("re_e6_ack", 64'(BUS_ACK), 64'h1);
    chk("re_e6_err", 64'(BUS_ERR), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
